// File: rtl/uart_rx_mmio.sv
// 8N1 UART receiver with an RX FIFO exposed as DATA/STATUS registers.
// Reading DATA pops the FIFO; reading STATUS clears the sticky error flags.
module uart_rx_mmio #(
  parameter int CLK_FREQ   = 27000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  input  logic        uart_ren,
  input  logic [3:0]  addr,
  output logic [31:0] uart_out
);

  localparam int CPB  = CLK_FREQ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int BW   = $clog2(CPB);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic          rx_m, rx_s;
  state_t        state_q, state_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tick, push, ferr_ev;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          overflow, frame_err;
  logic          full, empty, do_pop, do_push, ovf_ev, clr;
  logic [4:0]    count5;
  logic          unused_addr;

  assign unused_addr = ^addr[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= uart_rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Every phase samples when the baud counter reaches zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    push    = 1'b0;
    ferr_ev = 1'b0;
    tick    = (cnt_q == '0);
    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          cnt_d   = BW'(HALF - 1);
          state_d = S_START;
        end
      end
      S_START: begin
        if (!tick) cnt_d = cnt_q - BW'(1);
        else if (rx_s) state_d = S_IDLE;
        else begin
          state_d = S_DATA;
          bit_d   = '0;
          cnt_d   = BW'(CPB - 1);
        end
      end
      S_DATA: begin
        if (!tick) cnt_d = cnt_q - BW'(1);
        else begin
          shift_d[bit_q] = rx_s;
          bit_d          = bit_q + 3'd1;
          cnt_d          = BW'(CPB - 1);
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        // Leave mid-stop-bit so a back-to-back start edge is not missed.
        if (!tick) cnt_d = cnt_q - BW'(1);
        else begin
          state_d = S_IDLE;
          push    = rx_s;
          ferr_ev = !rx_s;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = uart_ren && (addr[3:2] == 2'd0) && !empty;
  assign do_push = push && (!full || do_pop);
  assign ovf_ev  = push && full && !do_pop;
  assign clr     = uart_ren && (addr[3:2] == 2'd1);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= shift_q;
  end

  // A new error event in the same cycle as a STATUS read wins over the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      overflow  <= ovf_ev  | (overflow  & ~clr);
      frame_err <= ferr_ev | (frame_err & ~clr);
    end
  end

  assign count5 = 5'(count);

  always_comb begin
    uart_out = '0;
    case (addr[3:2])
      2'd0:    if (!empty) uart_out = {23'b0, 1'b1, mem[rd_ptr]};
      2'd1:    uart_out = {19'b0, count5, 4'b0, frame_err, overflow, full, !empty};
      default: uart_out = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Bench for uart_rx_mmio at 16 clocks/bit: directed tables and sequences,
// then random frames and reads checked against a queue-based model.
module tb_uart_rx_mmio;

  localparam int CPB = 16;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_rx = 1'b1;
  logic        uart_ren = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] uart_out;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0]  a;
    logic        ren;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [20];

  logic [7:0] mq [$];
  bit m_ovf, m_fe;

  uart_rx_mmio #(.CLK_FREQ(16), .BAUD(1), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .uart_ren(uart_ren),
    .addr(addr), .uart_out(uart_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) tick();
    end
    uart_rx = stop;
    repeat (CPB) tick();
    uart_rx = 1'b1;
    repeat (CPB) tick();
  endtask

  task automatic chk(input string nm, input logic [3:0] a, input logic ren,
                     input logic [31:0] exp);
    addr = a;
    uart_ren = ren;
    #1;
    n_vec++;
    if (uart_out !== exp) begin
      n_err++;
      $display("FAIL %s: uart_out=%h expected %h", nm, uart_out, exp);
    end
    tick();
    uart_ren = 1'b0;
    addr = '0;
  endtask

  function automatic logic [31:0] model_out(input logic [3:0] a);
    logic [31:0] r;
    int n;
    n = mq.size();
    r = '0;
    if (a[3:2] == 2'd0 && n > 0) r = 32'h100 | 32'(mq[0]);
    else if (a[3:2] == 2'd1)
      r = (32'(n) << 8) | (32'(m_fe) << 3) | (32'(m_ovf) << 2)
        | (32'(n == DEPTH) << 1) | 32'(n > 0);
    return r;
  endfunction

  task automatic model_read(input logic [3:0] a, input logic ren);
    chk("rand_read", a, ren, model_out(a));
    if (ren && a[3:2] == 2'd0 && mq.size() > 0) void'(mq.pop_front());
    if (ren && a[3:2] == 2'd1) begin
      m_ovf = 1'b0;
      m_fe = 1'b0;
    end
  endtask

  task automatic model_rx(input logic [7:0] b, input logic stop);
    if (!stop) m_fe = 1'b1;
    else if (mq.size() == DEPTH) m_ovf = 1'b1;
    else mq.push_back(b);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    uart_rx = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    logic stop;

    tbl[0] = '{4'h4, 1'b0, 32'h0000_1007};
    for (int i = 0; i < 16; i++) tbl[1 + i] = '{4'h0, 1'b1, 32'h100 + 32'(i)};
    tbl[17] = '{4'h0, 1'b0, 32'h0};
    tbl[18] = '{4'h4, 1'b1, 32'h4};
    tbl[19] = '{4'h4, 1'b0, 32'h0};

    @(posedge clk);
    #1;
    do_reset();

    chk("reset_status", 4'h4, 1'b0, 32'h0);
    chk("reset_data", 4'h0, 1'b0, 32'h0);
    chk("empty_pop", 4'h0, 1'b1, 32'h0);
    chk("empty_pop_status", 4'h4, 1'b0, 32'h0);
    chk("addr8_zero", 4'h8, 1'b1, 32'h0);

    send_frame(8'hA5, 1'b1);
    chk("a5_status", 4'h4, 1'b0, 32'h101);
    chk("a5_data", 4'h0, 1'b0, 32'h1A5);
    chk("a5_pop", 4'h0, 1'b1, 32'h1A5);
    chk("a5_after_pop", 4'h4, 1'b0, 32'h0);

    for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1);
    for (int i = 0; i < 20; i++) chk("ovf_table", tbl[i].a, tbl[i].ren, tbl[i].exp);

    send_frame(8'h11, 1'b1);
    send_frame(8'h3C, 1'b0);
    chk("ferr_status", 4'h4, 1'b1, 32'h109);
    chk("ferr_cleared", 4'h4, 1'b0, 32'h101);
    fork
      send_frame(8'h3C, 1'b0);
      begin
        repeat (154) tick();
        chk("ferr_clear_edge", 4'h4, 1'b1, 32'h101);
      end
    join
    chk("ferr_set_wins", 4'h4, 1'b1, 32'h109);
    chk("ferr_data", 4'h0, 1'b1, 32'h111);
    chk("ferr_final", 4'h4, 1'b0, 32'h0);

    uart_rx = 1'b0;
    repeat (4) tick();
    uart_rx = 1'b1;
    repeat (40) tick();
    chk("glitch_status", 4'h4, 1'b0, 32'h0);
    fork
      send_frame(8'hF0, 1'b1);
      begin
        repeat (100) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
      end
    join
    chk("midframe_rst", 4'h4, 1'b0, 32'h0);
    send_frame(8'h5A, 1'b1);
    chk("after_rst_data", 4'h0, 1'b1, 32'h15A);
    chk("after_rst_status", 4'h4, 1'b0, 32'h0);

    for (int i = 0; i < 16; i++) send_frame(8'h20 + 8'(i), 1'b1);
    chk("full_status", 4'h4, 1'b0, 32'h1003);
    fork
      send_frame(8'h77, 1'b1);
      begin
        repeat (154) tick();
        chk("pop_at_push", 4'h0, 1'b1, 32'h120);
      end
    join
    chk("full_no_ovf", 4'h4, 1'b0, 32'h1003);
    for (int i = 1; i < 16; i++) chk("drain", 4'h0, 1'b1, 32'h120 + 32'(i));
    chk("tail_byte", 4'h0, 1'b1, 32'h177);
    chk("drained", 4'h4, 1'b0, 32'h0);

    do_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_fe = 1'b0;
    for (int f = 0; f < 24; f++) begin
      b = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      send_frame(b, stop);
      model_rx(b, stop);
      for (int k = 0; k < int'($urandom_range(0, 3)); k++)
        model_read({2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))},
                   1'($urandom_range(0, 1)));
    end
    for (int k = 0; k < DEPTH + 1; k++) model_read(4'h0, 1'b1);
    model_read(4'h4, 1'b1);
    model_read(4'h4, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
